// File: rtl/alu_operand_issue.sv
// Issue stage in front of the ALU: register file, per-register scoreboard,
// writeback bypass and a registered opcode/operand triple for the ALU.
module alu_operand_issue #(
  parameter int BITS  = 8,
  parameter int ALUOP = 4,
  parameter int REGS  = 8,
  parameter int RA    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ALUOP-1:0] in_op,
  input  logic [RA-1:0]    in_rd,
  input  logic [RA-1:0]    in_rs1,
  input  logic [RA-1:0]    in_rs2,
  input  logic [BITS-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALUOP-1:0] aluFunction,
  output logic [BITS-1:0]  vectorA,
  output logic [BITS-1:0]  vectorB,
  output logic [RA-1:0]    out_rd,
  input  logic             wb_en,
  input  logic [RA-1:0]    wb_addr,
  input  logic [BITS-1:0]  wb_data,
  output logic             illegal
);

  logic [BITS-1:0]  rf_q [REGS];
  logic [REGS-1:0]  pend_q, pend_d;
  logic             out_valid_q;
  logic [ALUOP-1:0] fn_q;
  logic [BITS-1:0]  a_q, b_q;
  logic [RA-1:0]    rd_q;
  logic             illegal_q;

  logic             legal, use_imm, wb_live;
  logic             byp1, byp2, bypd;
  logic             hazard, accept, fire;
  logic [BITS-1:0]  op_a, op_b;

  // Decode, hazard detection, operand selection and scoreboard next state.
  // Register 0 is never bypassed so a writeback to it cannot leak into a read.
  always_comb begin
    legal   = (in_op >= ALUOP'(1)) && (in_op <= ALUOP'(11));
    use_imm = (in_op == ALUOP'(6)) || (in_op == ALUOP'(7));
    wb_live = wb_en && (wb_addr != '0);
    byp1    = wb_live && (wb_addr == in_rs1);
    byp2    = wb_live && (wb_addr == in_rs2);
    bypd    = wb_live && (wb_addr == in_rd);

    hazard  = (pend_q[in_rd] && !bypd) ||
              (!use_imm && ((pend_q[in_rs1] && !byp1) || (pend_q[in_rs2] && !byp2)));
    in_ready = (!out_valid_q || out_ready) && !hazard;
    accept   = in_valid && in_ready;
    fire     = accept && legal;

    if (use_imm)              op_a = in_imm;
    else if (in_rs1 == '0)    op_a = '0;
    else if (byp1)            op_a = wb_data;
    else                      op_a = rf_q[in_rs1];

    if (use_imm)              op_b = in_imm;
    else if (in_rs2 == '0)    op_b = '0;
    else if (byp2)            op_b = wb_data;
    else                      op_b = rf_q[in_rs2];

    // Clear on writeback first so a same-cycle issue to that register wins.
    pend_d = pend_q;
    if (wb_live)                 pend_d[wb_addr] = 1'b0;
    if (fire && (in_rd != '0))   pend_d[in_rd]   = 1'b1;
  end

  // Register file and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REGS; i++) rf_q[i] <= '0;
      pend_q <= '0;
    end else begin
      if (wb_live) rf_q[wb_addr] <= wb_data;
      pend_q <= pend_d;
    end
  end

  // Output register toward the ALU plus the illegal-opcode pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      fn_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;
      if (fire) begin
        out_valid_q <= 1'b1;
        fn_q        <= in_op;
        a_q         <= op_a;
        b_q         <= op_b;
        rd_q        <= in_rd;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign aluFunction = fn_q;
  assign vectorA     = a_q;
  assign vectorB     = b_q;
  assign out_rd      = rd_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed vector table, hand sequences for
// stall/back-to-back and asynchronous reset, then random traffic vs a model.
module tb_alu_operand_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic [7:0] in_imm;
  logic       out_valid, out_ready;
  logic [3:0] aluFunction;
  logic [7:0] vectorA, vectorB;
  logic [2:0] out_rd;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       illegal;

  alu_operand_issue #(.BITS(8), .ALUOP(4), .REGS(8), .RA(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluFunction(aluFunction), .vectorA(vectorA), .vectorB(vectorB), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm,
                       input logic ordy, input logic wbe, input logic [2:0] wba,
                       input logic [7:0] wbd);
    @(negedge clk);
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    out_ready = ordy; wb_en = wbe; wb_addr = wba; wb_data = wbd;
  endtask

  // Samples in_ready just after the drive, then steps past the rising edge.
  task automatic tick(output logic rdy_s);
    #1 rdy_s = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [3:0] fn,
                         input logic [7:0] a, input logic [7:0] b, input logic [2:0] rd,
                         input logic ill);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ill));
    chk({tag, ".aluFunction"}, 32'(aluFunction), 32'(fn));
    chk({tag, ".vectorA"}, 32'(vectorA), 32'(a));
    chk({tag, ".vectorB"}, 32'(vectorB), 32'(b));
    chk({tag, ".out_rd"}, 32'(out_rd), 32'(rd));
  endtask

  typedef struct {
    logic       v;   logic [3:0] op;  logic [2:0] rd;  logic [2:0] rs1; logic [2:0] rs2;
    logic [7:0] imm; logic ordy;      logic wbe;       logic [2:0] wba; logic [7:0] wbd;
    logic       erdy; logic eov;      logic [3:0] efn; logic [7:0] ea;  logic [7:0] eb;
    logic [2:0] erd; logic eill;
  } vec_t;

  vec_t vt [11];

  // Reference model state: architectural registers, pending set, output slot.
  logic [7:0] mreg [8];
  logic       mpend [8];
  logic       mov, mill;
  logic [3:0] mfn;
  logic [7:0] ma, mb;
  logic [2:0] mrd;

  function automatic logic [7:0] m_src(input logic [2:0] r);
    if (r == 3'd0) return 8'h00;
    if (wb_en && wb_addr == r) return wb_data;
    return mreg[r];
  endfunction

  function automatic logic m_blocked(input logic [2:0] r);
    return mpend[r] && !(wb_en && wb_addr == r && r != 3'd0);
  endfunction

  function automatic logic m_ready();
    logic immop;
    immop = (in_op == 4'd6) || (in_op == 4'd7);
    if (mov && !out_ready) return 1'b0;
    if (m_blocked(in_rd)) return 1'b0;
    if (!immop && (m_blocked(in_rs1) || m_blocked(in_rs2))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_step(input logic rdy);
    logic lg, immop, took;
    logic [7:0] a, b;
    lg    = (in_op >= 4'd1) && (in_op <= 4'd11);
    immop = (in_op == 4'd6) || (in_op == 4'd7);
    took  = in_valid && rdy;
    a = immop ? in_imm : m_src(in_rs1);
    b = immop ? in_imm : m_src(in_rs2);
    mill = took && !lg;
    if (took && lg) begin
      mov = 1'b1; mfn = in_op; ma = a; mb = b; mrd = in_rd;
    end else if (out_ready) begin
      mov = 1'b0;
    end
    if (wb_en && wb_addr != 3'd0) begin
      mreg[wb_addr]  = wb_data;
      mpend[wb_addr] = 1'b0;
    end
    if (took && lg && in_rd != 3'd0) mpend[in_rd] = 1'b1;
  endtask

  logic r;

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;

    //           v op  rd rs1 rs2 imm    ordy wbe wba wbd  | erdy eov efn ea     eb     erd eill
    vt[0]  = '{0, 0,  0, 0,  0,  8'h00, 1,   1,  1,  8'h05, 1,   0,  0,  8'h00, 8'h00, 0,  0};
    vt[1]  = '{0, 0,  0, 0,  0,  8'h00, 1,   1,  2,  8'h03, 1,   0,  0,  8'h00, 8'h00, 0,  0};
    vt[2]  = '{1, 1,  3, 1,  2,  8'h00, 1,   0,  0,  8'h00, 1,   1,  1,  8'h05, 8'h03, 3,  0};
    vt[3]  = '{1, 2,  4, 3,  0,  8'h00, 1,   0,  0,  8'h00, 0,   0,  1,  8'h05, 8'h03, 3,  0};
    vt[4]  = '{1, 2,  4, 3,  0,  8'h00, 1,   1,  3,  8'h08, 1,   1,  2,  8'h08, 8'h00, 4,  0};
    vt[5]  = '{1, 6,  6, 4,  4,  8'hA5, 1,   0,  0,  8'h00, 1,   1,  6,  8'hA5, 8'hA5, 6,  0};
    vt[6]  = '{1, 0,  1, 1,  2,  8'h00, 1,   0,  0,  8'h00, 1,   0,  6,  8'hA5, 8'hA5, 6,  1};
    vt[7]  = '{1, 13, 2, 0,  0,  8'h00, 1,   0,  0,  8'h00, 1,   0,  6,  8'hA5, 8'hA5, 6,  1};
    vt[8]  = '{0, 0,  0, 0,  0,  8'h00, 1,   1,  0,  8'hFF, 1,   0,  6,  8'hA5, 8'hA5, 6,  0};
    vt[9]  = '{1, 3,  5, 0,  0,  8'h00, 1,   1,  0,  8'hFF, 1,   1,  3,  8'h00, 8'h00, 5,  0};
    vt[10] = '{1, 1,  7, 1,  2,  8'h00, 1,   0,  0,  8'h00, 1,   1,  1,  8'h05, 8'h03, 7,  0};

    repeat (2) @(negedge clk);
    #2 chk_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].v, vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm,
            vt[i].ordy, vt[i].wbe, vt[i].wba, vt[i].wbd);
      tick(r);
      chk($sformatf("vec%0d.in_ready", i), 32'(r), 32'(vt[i].erdy));
      chk_out($sformatf("vec%0d", i), vt[i].eov, vt[i].efn, vt[i].ea, vt[i].eb,
              vt[i].erd, vt[i].eill);
    end

    // Retire outstanding destinations 4..7.
    for (int k = 4; k < 8; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 1, 3'(k), 8'(8'h10 + k));
      tick(r);
    end

    // Stall for three cycles, then release with a waiting instruction.
    drive(1, 4, 1, 1, 2, 0, 1, 0, 0, 0);
    tick(r);
    chk("stall.issue.in_ready", 32'(r), 32'd1);
    chk_out("stall.issue", 1, 4, 8'h05, 8'h03, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 5, 2, 3, 3, 0, 0, 0, 0, 0);
      tick(r);
      chk($sformatf("stall%0d.in_ready", k), 32'(r), 32'd0);
      chk_out($sformatf("stall%0d", k), 1, 4, 8'h05, 8'h03, 1, 0);
    end
    drive(1, 5, 2, 3, 3, 0, 1, 0, 0, 0);
    tick(r);
    chk("release.in_ready", 32'(r), 32'd1);
    chk_out("release", 1, 5, 8'h08, 8'h08, 2, 0);
    drive(1, 9, 4, 3, 0, 0, 1, 0, 0, 0);
    tick(r);
    chk("b2b.in_ready", 32'(r), 32'd1);
    chk_out("b2b", 1, 9, 8'h08, 8'h00, 4, 0);

    // Asynchronous reset while stalled with pending destinations 1, 2, 4.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 8'h77);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_en = 1'b0;
    drive(1, 1, 1, 3, 1, 0, 1, 0, 0, 0);
    tick(r);
    chk("post_rst.pend1", 32'(r), 32'd1);
    chk_out("post_rst.a", 1, 1, 8'h00, 8'h00, 1, 0);
    drive(1, 1, 2, 2, 4, 0, 1, 0, 0, 0);
    tick(r);
    chk("post_rst.pend2", 32'(r), 32'd1);
    chk_out("post_rst.b", 1, 1, 8'h00, 8'h00, 2, 0);

    // Random traffic against the reference model, starting from reset.
    @(negedge clk);
    rst_n = 1'b0; in_valid = 0; wb_en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin mreg[k] = 8'h00; mpend[k] = 1'b0; end
    mov = 0; mill = 0; mfn = 0; ma = 0; mb = 0; mrd = 0;
    for (int n = 0; n < 400; n++) begin
      logic er;
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 4),
            3'($urandom_range(0, 7)), 8'($urandom));
      #1 er = m_ready();
      m_step(er);
      r = in_ready;
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d.in_ready", n), 32'(r), 32'(er));
      chk($sformatf("rnd%0d.out_valid", n), 32'(out_valid), 32'(mov));
      chk($sformatf("rnd%0d.illegal", n), 32'(illegal), 32'(mill));
      if (mov) begin
        chk($sformatf("rnd%0d.aluFunction", n), 32'(aluFunction), 32'(mfn));
        chk($sformatf("rnd%0d.vectorA", n), 32'(vectorA), 32'(ma));
        chk($sformatf("rnd%0d.vectorB", n), 32'(vectorB), 32'(mb));
        chk($sformatf("rnd%0d.out_rd", n), 32'(out_rd), 32'(mrd));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Issue stage directly upstream of the ALU. Accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file.
- Resolves read-after-write and write-after-write hazards with a per-register scoreboard.
- Presents a registered aluFunction/vectorA/vectorB triple to the ALU.
- The downstream writeback stage returns results through a write port, which updates the register file and clears the scoreboard.

Parameters:
- BITS, 8, datapath width; matches ALU BITS.
- ALUOP, 4, opcode width; matches ALU ALUOP.
- REGS, 8, register count; power of two, minimum 2.
- RA, 3, register address width; equals log2(REGS).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_op  in  ALUOP  ALU function code.
- in_rd  in  RA  destination register.
- in_rs1  in  RA  source A register.
- in_rs2  in  RA  source B register.
- in_imm  in  BITS  scalar immediate.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream accepts.
- aluFunction  out  ALUOP  registered opcode to ALU.
- vectorA  out  BITS  registered operand A.
- vectorB  out  BITS  registered operand B.
- out_rd  out  RA  destination carried alongside the operands.
- wb_en  in  1  writeback strobe.
- wb_addr  in  RA  writeback register.
- wb_data  in  BITS  writeback value.
- illegal  out  1  one-cycle pulse when an illegal opcode is dropped.

Behaviour:
- Reset: asynchronous, active-low, fixed; all asserted on rst_n low regardless of clock. Values during reset:
  - out_valid=0; aluFunction, vectorA, vectorB, out_rd = 0; illegal=0.
  - All register file entries = 0; all scoreboard bits = 0.
- Register 0: reads return 0; writes to it are ignored; it is never marked pending.
- Legal opcodes: 1..11. Opcodes 0 and 12..15 are illegal:
  - Accepted when in_ready=1.
  - Not issued, scoreboard unchanged, illegal=1 on the following cycle.
- Operand select:
  - Opcodes 6 and 7: vectorA=in_imm and vectorB=in_imm; rs1/rs2 are ignored for hazard checks.
  - All other legal opcodes: vectorA=R[rs1], vectorB=R[rs2].
- Bypass: when wb_en=1 and wb_addr matches a source register in the same cycle, the operand takes wb_data and that source is not treated as a hazard.
- Hazard: exists when pend[rs1], pend[rs2] (only for sources used) or pend[rd] is set and no same-cycle writeback bypass clears it. The pend[rd] check is WAW protection.
- in_ready = (!out_valid || out_ready) && !hazard. in_ready is combinational from inputs and state.
- Fire: in_valid && in_ready with a legal opcode. Next edge:
  - Load the output register.
  - out_valid=1.
  - pend[rd]=1 unless rd=0.
- Output hold: when out_valid && !out_ready, aluFunction, vectorA, vectorB and out_rd hold stable.
- Output drain: when out_ready && no fire, out_valid clears.
- Throughput: one instruction per cycle when there are no hazards and out_ready=1. Latency is 1 cycle from fire to out_valid.
- Writeback:
  - wb_en writes R[wb_addr] and clears pend[wb_addr] on the edge.
  - If a fire sets pend for the same address that cycle, set wins.
  - A writeback to a non-pending register still writes.
- Reset mid-operation discards the in-flight output and any pending state; wb_en during reset is ignored.

Test Plan:
- Reset, write R1=0x05, R2=0x03 via wb, issue op=1 rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, aluFunction=1, vectorA=0x05, vectorB=0x03, out_rd=3, pend[3]=1.
- Issue rd=3, then issue rs1=3 with no wb -> in_ready=0. Assert wb_en addr=3 data=0x08 -> in_ready=1 that cycle and vectorA=0x08 (bypass).
- Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0. Raise out_ready with a new valid instruction -> back-to-back issue with no bubble.
- op=6 in_imm=0xA5 rs1=rs2=5 with pend[5]=1 -> issues immediately, vectorA=vectorB=0xA5.
- op=0 and op=13 -> no out_valid, illegal pulses one cycle each, scoreboard unchanged. wb to addr 0 data 0xFF, then read rs1=0 -> vectorA=0x00.
- Assert rst_n=0 asynchronously mid-stall with pend set -> out_valid=0 immediately, all registers and pending bits read 0 after release.
